// File: rtl/ifetch_sequencer.sv
// Fetches 4 ROM bytes (big-endian) per instruction and presents them to decode.
// Latency: first rom_rd_en in cycle t, instr_valid from t+5; 6 cycles/instr with ready high.
// Backpressure: instr/instr_pc/instr_valid hold while instr_ready=0; no new ROM reads meanwhile.
module ifetch_sequencer #(
    parameter int                 ADDR_W    = 32,
    parameter int                 ROM_DEPTH = 256,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd_en,
    input  logic [7:0]        rom_data,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              fetch_fault
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LAST,
        VALID,
        FAULT
    } state_t;

    // Highest byte address at which a whole 4-byte word still fits in the ROM.
    localparam logic [ADDR_W-1:0] MAX_PC = ADDR_W'(ROM_DEPTH - 4);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        k;
    logic [ADDR_W-1:0] pc_next;

    function automatic logic pc_legal(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (a <= MAX_PC);
    endfunction

    // Sequential successor of the current word, wrapping at ADDR_W.
    always_comb begin
        pc_next = pc + ADDR_W'(4);
    end

    // Fetch FSM: redirect overrides everything but reset; handshake chains straight into the next fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            k           <= 2'd0;
            rom_rd_en   <= 1'b0;
            rom_addr    <= RESET_PC;
            instr       <= 32'd0;
            instr_pc    <= RESET_PC;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (branch_valid) begin
            // Abort whatever is in flight; late bytes land while in IDLE and are never captured.
            state       <= IDLE;
            pc          <= branch_target;
            k           <= 2'd0;
            rom_rd_en   <= 1'b0;
            rom_addr    <= branch_target;
            instr_valid <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (pc_legal(pc)) begin
                            state     <= REQ;
                            k         <= 2'd0;
                            rom_rd_en <= 1'b1;
                            rom_addr  <= pc;
                        end else begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // Byte for the address issued last cycle is on rom_data now (none yet when k==0).
                    if (k != 2'd0) begin
                        instr <= {instr[23:0], rom_data};
                    end
                    if (k == 2'd3) begin
                        rom_rd_en <= 1'b0;
                        state     <= LAST;
                    end else begin
                        k        <= k + 2'd1;
                        rom_addr <= rom_addr + ADDR_W'(1);
                    end
                end
                LAST: begin
                    instr       <= {instr[23:0], rom_data};
                    instr_pc    <= pc;
                    instr_valid <= 1'b1;
                    state       <= VALID;
                end
                VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        pc          <= pc_next;
                        if (enable && pc_legal(pc_next)) begin
                            state     <= REQ;
                            k         <= 2'd0;
                            rom_rd_en <= 1'b1;
                            rom_addr  <= pc_next;
                        end else begin
                            // Disabled or illegal successor: IDLE decides next cycle.
                            state <= IDLE;
                        end
                    end
                end
                FAULT: begin
                    fetch_fault <= 1'b1;
                    rom_rd_en   <= 1'b0;
                    instr_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Bench for ifetch_sequencer: byte ROM model, delivery scoreboard, branch-target vector table.
// Latency: checks the exact t..t+5 timing of a fetch and the 6-cycle chaining.
// Backpressure: holds instr_ready low and checks the held instruction and idle ROM port.
module tb_ifetch_sequencer;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd_en;
    logic [7:0]        rom_data;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_valid;
    logic [ADDR_W-1:0] branch_target;
    logic              fetch_fault;

    ifetch_sequencer #(.ADDR_W(ADDR_W), .ROM_DEPTH(256), .RESET_PC('0)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .rom_addr      (rom_addr),
        .rom_rd_en     (rom_rd_en),
        .rom_data      (rom_data),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .fetch_fault   (fetch_fault)
    );

    always #5 clk = ~clk;

    // Byte-wide ROM with one cycle of read latency.
    logic [7:0] mem [256];
    initial rom_data = 8'h00;
    always @(posedge clk) begin
        if (rom_rd_en) rom_data <= mem[rom_addr[7:0]];
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        logic        fault;
        logic [31:0] instr;
    } vec_t;

    exp_t sb[$];
    int   tests = 0;
    int   failures = 0;
    int   deliveries = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem[a[7:0]], mem[8'(a[7:0] + 8'd1)], mem[8'(a[7:0] + 8'd2)], mem[8'(a[7:0] + 8'd3)]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.instr = word_at(a);
        e.pc    = a;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        branch_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_rd(input string name);
        int n = 0;
        while (!rom_rd_en && n < 20) begin step(); n++; end
        if (!rom_rd_en) timeout(name);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 20) begin step(); n++; end
        if (!instr_valid) timeout(name);
    endtask

    task automatic wait_deliv(input int target, input string name);
        int n = 0;
        while (deliveries < target && n < 40) begin step(); n++; end
        if (deliveries < target) timeout(name);
    endtask

    task automatic check_reset_outs(input string name);
        check({name, "_rd_en"}, 64'(rom_rd_en), 64'd0);
        check({name, "_addr"},  64'(rom_addr), 64'd0);
        check({name, "_instr"}, 64'(instr), 64'd0);
        check({name, "_ipc"},   64'(instr_pc), 64'd0);
        check({name, "_valid"}, 64'(instr_valid), 64'd0);
        check({name, "_fault"}, 64'(fetch_fault), 64'd0);
    endtask

    // Scoreboard: every accepted instruction must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            exp_t e;
            deliveries++;
            tests++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_delivery: got instr=%h pc=%h, none expected", instr, instr_pc);
            end else begin
                e = sb.pop_front();
                if (instr !== e.instr || instr_pc !== e.pc) begin
                    failures++;
                    $display("FAIL delivery: got instr=%h pc=%h expected instr=%h pc=%h",
                             instr, instr_pc, e.instr, e.pc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   d0;

        for (int i = 0; i < 256; i++) mem[i] = 8'((i * 37 + 11) & 255);
        mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
        mem[4] = 8'h8C; mem[5] = 8'h01; mem[6] = 8'h00; mem[7] = 8'h04;

        vecs[0] = '{target: 32'h06,  fault: 1'b1, instr: 32'h0};
        vecs[1] = '{target: 32'h08,  fault: 1'b0, instr: word_at(32'h08)};
        vecs[2] = '{target: 32'hFE,  fault: 1'b1, instr: 32'h0};
        vecs[3] = '{target: 32'hFC,  fault: 1'b0, instr: word_at(32'hFC)};
        vecs[4] = '{target: 32'h100, fault: 1'b1, instr: 32'h0};
        vecs[5] = '{target: 32'h04,  fault: 1'b0, instr: 32'h8C010004};
        vecs[6] = '{target: 32'h05,  fault: 1'b1, instr: 32'h0};

        enable        = 1'b0;
        instr_ready   = 1'b0;
        branch_valid  = 1'b0;
        branch_target = '0;

        // Reset values while reset is held.
        reset = 1'b1;
        step();
        step();
        check_reset_outs("reset");

        // Basic fetch timing and 6-cycle chaining.
        enable      = 1'b1;
        instr_ready = 1'b1;
        push(32'h0);
        push(32'h4);
        reset = 1'b0;
        wait_rd("t1_start");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t1_addr%0d", k), {31'd0, rom_rd_en, rom_addr}, {31'd0, 1'b1, 32'(k)});
            step();
        end
        check("t1_last", {62'd0, rom_rd_en, instr_valid}, 64'd0);
        step();
        check("t1_valid", {31'd0, instr_valid, instr}, {31'd0, 1'b1, 32'h20080005});
        check("t1_ipc", 64'(instr_pc), 64'd0);
        step();
        check("t1_chain", {30'd0, instr_valid, rom_rd_en, rom_addr}, {30'd0, 1'b0, 1'b1, 32'h4});
        enable = 1'b0;
        wait_deliv(2, "t1_second");
        check("t1_instr2", 64'(instr), 64'h8C010004);

        // Backpressure.
        do_reset();
        enable      = 1'b1;
        instr_ready = 1'b0;
        push(32'h0);
        wait_valid("t2_valid");
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_hold%0d", i), {30'd0, instr_valid, rom_rd_en, instr},
                  {30'd0, 1'b1, 1'b0, 32'h20080005});
            step();
        end
        d0 = deliveries;
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        check("t2_one_hs", 64'(deliveries), 64'(d0 + 1));
        check("t2_next", {30'd0, instr_valid, rom_rd_en, rom_addr}, {30'd0, 1'b0, 1'b1, 32'h4});

        // Redirect in the middle of a fetch.
        do_reset();
        enable      = 1'b1;
        instr_ready = 1'b1;
        wait_rd("t3_start");
        step();
        step();
        check("t3_k2", 64'(rom_addr), 64'h2);
        branch_valid  = 1'b1;
        branch_target = 32'h10;
        push(32'h10);
        step();
        branch_valid = 1'b0;
        check("t3_abort", {62'd0, rom_rd_en, instr_valid}, 64'd0);
        wait_rd("t3_restart");
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_addr%0d", k), {31'd0, rom_rd_en, rom_addr}, {31'd0, 1'b1, 32'(32'h10 + k)});
            step();
        end
        wait_deliv(deliveries + 1, "t3_deliver");

        // Branch-target table: legality boundaries and fault stickiness/clearing.
        enable      = 1'b1;
        instr_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            int n;
            branch_valid  = 1'b1;
            branch_target = vecs[v].target;
            if (!vecs[v].fault) begin
                exp_t e;
                e.instr = vecs[v].instr;
                e.pc    = vecs[v].target;
                sb.push_back(e);
            end
            d0 = deliveries;
            step();
            branch_valid = 1'b0;
            check($sformatf("vec%0d_cleared", v), {62'd0, fetch_fault, instr_valid}, 64'd0);
            n = 0;
            while (!fetch_fault && !instr_valid && n < 20) begin step(); n++; end
            if (!fetch_fault && !instr_valid) timeout($sformatf("vec%0d_wait", v));
            check($sformatf("vec%0d_fault", v), 64'(fetch_fault), 64'(vecs[v].fault));
            if (vecs[v].fault) begin
                for (int i = 0; i < 3; i++) begin
                    step();
                    check($sformatf("vec%0d_sticky%0d", v, i), {61'd0, fetch_fault, rom_rd_en, instr_valid},
                          {61'd0, 1'b1, 1'b0, 1'b0});
                end
            end else begin
                wait_deliv(d0 + 1, $sformatf("vec%0d_deliver", v));
            end
        end

        // Reset while the last byte is being captured.
        enable      = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        push(32'h0);
        wait_rd("t5_start");
        step(); step(); step(); step();
        check("t5_in_last", {62'd0, rom_rd_en, instr_valid}, 64'd0);
        reset = 1'b1;
        step();
        check_reset_outs("t5_reset");
        reset = 1'b0;
        wait_rd("t5_restart");
        enable = 1'b0;
        check("t5_addr", 64'(rom_addr), 64'h0);
        wait_deliv(deliveries + 1, "t5_deliver");

        // Handshake and redirect in the same cycle.
        do_reset();
        enable      = 1'b1;
        instr_ready = 1'b1;
        push(32'h0);
        wait_valid("t6_valid");
        d0 = deliveries;
        branch_valid  = 1'b1;
        branch_target = 32'h20;
        push(32'h20);
        step();
        branch_valid = 1'b0;
        check("t6_one_delivery", 64'(deliveries), 64'(d0 + 1));
        check("t6_no_read", {62'd0, rom_rd_en, instr_valid}, 64'd0);
        wait_rd("t6_restart");
        enable = 1'b0;
        check("t6_addr", 64'(rom_addr), 64'h20);
        wait_deliv(d0 + 2, "t6_deliver");
        step();
        check("t6_total", 64'(deliveries), 64'(d0 + 2));

        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
